// File: rtl/map_fill_engine.sv
// Rectangle-fill engine for tile map port B: CPU register block, fill sequencer,
// and the port B mux that gives the CPU priority over engine writes.
module map_fill_engine #(
   parameter int ROW_BITS  = 5,
   parameter int COL_BITS  = 5,
   parameter int TILE_BITS = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 cs,
   input  logic                 read,
   input  logic                 write,
   input  logic [15:0]          low_address,
   input  logic [31:0]          data_in,
   output logic [31:0]          data_out,
   input  logic                 cpu_map_cs,
   input  logic                 cpu_map_read,
   input  logic                 cpu_map_write,
   input  logic [ROW_BITS-1:0]  cpu_row_index,
   input  logic [COL_BITS-1:0]  cpu_col_index,
   input  logic [TILE_BITS-1:0] cpu_map_data,
   output logic                 map_cs,
   output logic                 map_read,
   output logic                 map_write,
   output logic [ROW_BITS-1:0]  map_row_index,
   output logic [COL_BITS-1:0]  map_col_index,
   output logic [TILE_BITS-1:0] map_data,
   output logic                 busy,
   output logic                 irq
);

   typedef enum logic {S_IDLE, S_FILL} state_t;

   state_t               r_state, w_next;
   logic [ROW_BITS-1:0]  r_dest_row, r_cur_row;
   logic [COL_BITS-1:0]  r_dest_col, r_cur_col;
   logic [COL_BITS:0]    r_width, r_col_cnt;
   logic [ROW_BITS:0]    r_height, r_row_cnt;
   logic [TILE_BITS-1:0] r_value;
   logic                 r_done, r_irq_en;

   logic [1:0]  w_sel;
   logic        w_wr, w_ctrl_wr, w_start, w_abort, w_clear;
   logic        w_busy, w_size_ok, w_eng, w_col_more, w_row_more;
   logic [31:0] w_rdata;
   logic        w_unused;

   assign w_sel      = low_address[3:2];
   assign w_wr       = cs & write;
   assign w_ctrl_wr  = w_wr && (w_sel == 2'd0);
   assign w_abort    = w_ctrl_wr & data_in[1];
   assign w_start    = w_ctrl_wr & data_in[0] & ~data_in[1];
   assign w_clear    = w_ctrl_wr & data_in[2];
   assign w_busy     = (r_state == S_FILL);
   assign w_size_ok  = (r_width != '0) && (r_height != '0);
   // An abort arriving this cycle also suppresses this cycle's engine write
   assign w_eng      = w_busy & ~cpu_map_cs & ~w_abort;
   assign w_col_more = r_col_cnt > (COL_BITS+1)'(1);
   assign w_row_more = r_row_cnt > (ROW_BITS+1)'(1);
   assign w_unused   = ^{low_address, data_in};

   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_start && w_size_ok) w_next = S_FILL;
         S_FILL: begin
            if (w_abort) w_next = S_IDLE;
            else if (w_eng && !w_col_more && !w_row_more) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_dest_row <= '0;
         r_dest_col <= '0;
         r_width    <= '0;
         r_height   <= '0;
         r_value    <= '0;
         r_done     <= 1'b0;
         r_irq_en   <= 1'b0;
         r_cur_row  <= '0;
         r_cur_col  <= '0;
         r_col_cnt  <= '0;
         r_row_cnt  <= '0;
      end else begin
         if (w_ctrl_wr) r_irq_en <= data_in[3];
         if (w_wr && !w_busy) begin
            case (w_sel)
               2'd1: begin
                  r_dest_row <= data_in[ROW_BITS+7:8];
                  r_dest_col <= data_in[COL_BITS-1:0];
               end
               2'd2: begin
                  r_height <= data_in[ROW_BITS+8:8];
                  r_width  <= data_in[COL_BITS:0];
               end
               2'd3:    r_value <= data_in[TILE_BITS-1:0];
               default: ;
            endcase
         end
         if (w_clear) r_done <= 1'b0;
         // Start is evaluated after clear_done so its outcome overrides it
         if (!w_busy && w_start) begin
            if (w_size_ok) begin
               r_cur_row <= r_dest_row;
               r_cur_col <= r_dest_col;
               r_col_cnt <= r_width;
               r_row_cnt <= r_height;
               r_done    <= 1'b0;
            end else begin
               r_done    <= 1'b1;
            end
         end
         if (w_eng) begin
            if (w_col_more) begin
               r_cur_col <= r_cur_col + 1'b1;
               r_col_cnt <= r_col_cnt - 1'b1;
            end else if (w_row_more) begin
               r_cur_col <= r_dest_col;
               r_col_cnt <= r_width;
               r_cur_row <= r_cur_row + 1'b1;
               r_row_cnt <= r_row_cnt - 1'b1;
            end else begin
               r_done    <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      map_cs        = cpu_map_cs;
      map_read      = cpu_map_read;
      map_write     = cpu_map_write;
      map_row_index = cpu_row_index;
      map_col_index = cpu_col_index;
      map_data      = cpu_map_data;
      if (w_eng) begin
         map_cs        = 1'b1;
         map_read      = 1'b0;
         map_write     = 1'b1;
         map_row_index = r_cur_row;
         map_col_index = r_cur_col;
         map_data      = r_value;
      end
   end

   always_comb begin
      w_rdata = '0;
      case (w_sel)
         2'd0: begin
            w_rdata[0] = w_busy;
            w_rdata[1] = r_done;
            w_rdata[3] = r_irq_en;
         end
         2'd1: begin
            w_rdata[ROW_BITS+7:8] = r_dest_row;
            w_rdata[COL_BITS-1:0] = r_dest_col;
         end
         2'd2: begin
            w_rdata[ROW_BITS+8:8] = r_height;
            w_rdata[COL_BITS:0]   = r_width;
         end
         default: w_rdata[TILE_BITS-1:0] = r_value;
      endcase
   end

   assign data_out = (cs & read) ? w_rdata : 32'd0;
   assign busy     = w_busy;
   assign irq      = r_done & r_irq_en;

endmodule
